// File: rtl/apb_gpio_pkg.sv
// Shared constants, CONFIG field positions and interrupt/IO type encodings for apb_gpio.
// Used by apb_gpio (top) and apb_gpio_bit (per-pin slice).
package apb_gpio_pkg;

    localparam logic [7:0] ADDR_CFG_BASE = 8'h00;
    localparam logic [7:0] ADDR_INTR     = 8'h80;
    localparam logic [7:0] ADDR_IN       = 8'h90;
    localparam logic [7:0] ADDR_OUT      = 8'hA0;

    localparam int CFG_OUT_EN   = 0;
    localparam int CFG_IN_EN    = 1;
    localparam int CFG_OE       = 2;
    localparam int CFG_INT_EN   = 3;
    localparam int CFG_RSVD     = 4;
    localparam int CFG_TYPE_LSB = 5;

    // Bit 4 is reserved and must always read back as 0.
    localparam logic [7:0] CFG_WR_MASK = ~(8'h01 << CFG_RSVD);

    typedef enum logic [2:0] {
        LVL_HI    = 3'd0,
        LVL_LO    = 3'd1,
        EDGE_POS  = 3'd2,
        EDGE_NEG  = 3'd3,
        EDGE_BOTH = 3'd4
    } int_type_e;

    typedef enum logic [1:0] {
        IO_INPUT  = 2'd0,
        IO_OUTPUT = 2'd1,
        IO_BIDIR  = 2'd2
    } io_type_e;

    // Hard-wired CONFIG value for a pin whose configuration is fixed at build time.
    function automatic logic [7:0] fixed_cfg(input logic [1:0] io_type, input logic [2:0] int_type);
        logic [7:0] type_field;
        type_field = {int_type, 5'b00000};
        case (io_type_e'(io_type))
            IO_OUTPUT: fixed_cfg = 8'h05;
            IO_BIDIR:  fixed_cfg = 8'h0F | type_field;
            default:   fixed_cfg = 8'h0A | type_field;
        endcase
    endfunction

endpackage

// File: rtl/apb_gpio_bit.sv
// One GPIO pin slice: CONFIG register (writable or fixed), edge/level detector and
// sticky interrupt flag with write-1-to-clear, where a same-cycle set beats the clear.
module apb_gpio_bit
    import apb_gpio_pkg::*;
#(
    parameter bit         FIXED     = 1'b0,
    parameter logic [7:0] FIXED_VAL = 8'h00
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       cfg_we,
    input  logic [7:0] cfg_wdata,
    input  logic       in_bit,
    input  logic       intr_clr,
    output logic [7:0] cfg,
    output logic       intr
);

    logic [7:0] cfg_q;
    logic       prev_q;
    logic       hit;
    int_type_e  itype;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cfg_q <= FIXED ? FIXED_VAL : 8'h00;
        end else if (cfg_we && !FIXED) begin
            cfg_q <= cfg_wdata & CFG_WR_MASK;
        end
    end

    assign cfg   = FIXED ? FIXED_VAL : cfg_q;
    assign itype = int_type_e'(cfg[7:CFG_TYPE_LSB]);

    // Types 5..7 select no interrupt source.
    always_comb begin
        hit = 1'b0;
        case (itype)
            LVL_HI:    hit = in_bit;
            LVL_LO:    hit = ~in_bit;
            EDGE_POS:  hit = in_bit & ~prev_q;
            EDGE_NEG:  hit = ~in_bit & prev_q;
            EDGE_BOTH: hit = in_bit ^ prev_q;
            default:   hit = 1'b0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            prev_q <= 1'b0;
            intr   <= 1'b0;
        end else begin
            prev_q <= in_bit;
            intr   <= (hit & cfg[CFG_INT_EN]) | (intr & ~intr_clr);
        end
    end

endmodule

// File: rtl/apb_gpio.sv
// APB GPIO block: APB decode, byte/halfword lane handling, readback mux and pad-side outputs.
// Optional build macro APB_GPIO_SYNC_EN inserts a 2-flop synchronizer ahead of in_reg.
module apb_gpio
    import apb_gpio_pkg::*;
#(
    parameter int          IO_NUM       = 32,
    parameter int          APB_WIDTH    = 32,
    parameter bit          INT_BUS      = 1'b1,
    parameter logic [31:0] FIXED_CONFIG = 32'h0,
    parameter logic [63:0] IO_TYPE      = 64'h0,
    parameter logic [95:0] IO_INT_TYPE  = 96'h0
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [7:0]           PADDR,
    input  logic [APB_WIDTH-1:0] PWDATA,
    output logic [APB_WIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    input  logic [IO_NUM-1:0]    GPIO_IN,
    output logic [IO_NUM-1:0]    GPIO_OUT,
    output logic [IO_NUM-1:0]    GPIO_OE,
    output logic [IO_NUM-1:0]    INT,
    output logic                 INT_OR
);

    localparam int          LANE_SH   = $clog2(APB_WIDTH);
    localparam int          NLANES    = 32 / APB_WIDTH;
    localparam logic [31:0] LANE_ONES = 32'((64'd1 << APB_WIDTH) - 64'd1);

    logic [IO_NUM-1:0] in_reg;
    logic [IO_NUM-1:0] out_reg;
    logic [IO_NUM-1:0] intr_vec;
    logic [IO_NUM-1:0] cfg_out_en;
    logic [IO_NUM-1:0] cfg_in_en;
    logic [IO_NUM-1:0] cfg_oe;
    logic [7:0]        cfg_arr [IO_NUM];

    logic        wr_en;
    logic        rd_en;
    logic        aligned;
    logic [4:0]  pin_idx;
    logic [1:0]  lane;
    logic        lane_ok;
    logic [4:0]  shamt;
    logic        cfg_hit;
    logic        intr_hit;
    logic        in_hit;
    logic        out_hit;
    logic [31:0] wdata32;
    logic [31:0] wmask32;
    logic [31:0] wbits32;
    logic [31:0] rsel32;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & ~PWRITE;
    assign aligned = (PADDR[1:0] == 2'b00);
    assign pin_idx = PADDR[6:2];
    assign lane    = PADDR[3:2];
    assign lane_ok = (int'(lane) < NLANES);
    assign shamt   = 5'(int'(lane) << LANE_SH);

    // Narrow buses see each 32-bit register as NLANES consecutive word addresses.
    assign cfg_hit  = aligned & ~PADDR[7] & (int'(pin_idx) < IO_NUM);
    assign intr_hit = aligned & lane_ok & (PADDR[7:4] == ADDR_INTR[7:4]);
    assign in_hit   = aligned & lane_ok & (PADDR[7:4] == ADDR_IN[7:4]);
    assign out_hit  = aligned & lane_ok & (PADDR[7:4] == ADDR_OUT[7:4]);

    assign wdata32 = 32'(PWDATA);
    assign wmask32 = LANE_ONES << shamt;
    assign wbits32 = (wdata32 << shamt) & wmask32;

`ifdef APB_GPIO_SYNC_EN
    logic [IO_NUM-1:0] sync_p0;
    logic [IO_NUM-1:0] sync_p1;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            in_reg  <= '0;
        end else begin
            sync_p0 <= GPIO_IN;
            sync_p1 <= sync_p0;
            in_reg  <= sync_p1;
        end
    end
`else
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            in_reg <= '0;
        end else begin
            in_reg <= GPIO_IN;
        end
    end
`endif

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            out_reg <= '0;
        end else if (wr_en && out_hit) begin
            out_reg <= (out_reg & ~wmask32[IO_NUM-1:0]) | wbits32[IO_NUM-1:0];
        end
    end

    for (genvar n = 0; n < IO_NUM; n++) begin : g_pin
        apb_gpio_bit #(
            .FIXED     (FIXED_CONFIG[n]),
            .FIXED_VAL (fixed_cfg(IO_TYPE[2*n +: 2], IO_INT_TYPE[3*n +: 3]))
        ) u_bit (
            .PCLK      (PCLK),
            .PRESETN   (PRESETN),
            .cfg_we    (wr_en & cfg_hit & (int'(pin_idx) == n)),
            .cfg_wdata (wdata32[7:0]),
            .in_bit    (in_reg[n]),
            .intr_clr  (wr_en & intr_hit & wbits32[n]),
            .cfg       (cfg_arr[n]),
            .intr      (intr_vec[n])
        );

        assign cfg_out_en[n] = cfg_arr[n][CFG_OUT_EN];
        assign cfg_in_en[n]  = cfg_arr[n][CFG_IN_EN];
        assign cfg_oe[n]     = cfg_arr[n][CFG_OE];
    end

    always_comb begin
        rsel32 = '0;
        if (cfg_hit) begin
            for (int n = 0; n < IO_NUM; n++) begin
                if (int'(pin_idx) == n) begin
                    rsel32 = 32'(cfg_arr[n]);
                end
            end
        end else if (intr_hit) begin
            rsel32 = 32'(intr_vec) >> shamt;
        end else if (in_hit) begin
            rsel32 = 32'(in_reg & cfg_in_en) >> shamt;
        end else if (out_hit) begin
            rsel32 = 32'(out_reg) >> shamt;
        end
    end

    assign PRDATA  = rd_en ? rsel32[APB_WIDTH-1:0] : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign GPIO_OUT = out_reg & cfg_out_en;
    assign GPIO_OE  = cfg_oe;
    assign INT_OR   = |intr_vec;

    if (INT_BUS) begin : g_int_bus
        assign INT = intr_vec;
    end else begin : g_int_off
        assign INT = '0;
    end

endmodule

// File: tb/tb_apb_gpio.sv
// Scoreboard bench for apb_gpio: a 32-bit default instance and an 8-bit instance with pin 0 fixed as output.
module tb_apb_gpio;

`ifdef APB_GPIO_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        psel_a, psel_b, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] gpio_in;
    logic [31:0] prdata_a;
    logic [7:0]  prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [31:0] gout_a, goe_a, gint_a, gout_b, goe_b, gint_b;
    logic        int_or_a, int_or_b;
    logic        pin_chk;

    always #5 PCLK = ~PCLK;

    apb_gpio u_dut_a (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
        .GPIO_IN(gpio_in), .GPIO_OUT(gout_a), .GPIO_OE(goe_a), .INT(gint_a), .INT_OR(int_or_a)
    );

    apb_gpio #(.APB_WIDTH(8), .FIXED_CONFIG(32'h1), .IO_TYPE(64'h1)) u_dut_b (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA[7:0]), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
        .GPIO_IN(gpio_in), .GPIO_OUT(gout_b), .GPIO_OE(goe_b), .INT(gint_b), .INT_OR(int_or_b)
    );

    typedef struct { bit d; logic [7:0] addr; logic [31:0] exp; } rd_t;
    typedef struct { bit d; logic [31:0] out; logic [31:0] oe; logic [31:0] intv; logic int_or; } pin_t;

    rd_t  rd_q[$];
    pin_t pin_q[$];
    int   vectors = 0;
    int   fails = 0;

    // Reference model: register contents per instance (0 = 32-bit bus, 1 = 8-bit bus).
    logic [7:0]  cfg_m [2][32];
    logic [31:0] out_m [2];
    logic [31:0] intr_m[2];
    logic [31:0] pins_m;

    function automatic logic [31:0] field(int d, int b);
        logic [31:0] r = '0;
        for (int n = 0; n < 32; n++) r[n] = cfg_m[d][n][b];
        return r;
    endfunction

    function automatic logic [31:0] level_act(int d);
        logic [31:0] r = '0;
        for (int n = 0; n < 32; n++) begin
            if (cfg_m[d][n][3]) begin
                if (cfg_m[d][n][7:5] == 3'd0) r[n] = pins_m[n];
                if (cfg_m[d][n][7:5] == 3'd1) r[n] = ~pins_m[n];
            end
        end
        return r;
    endfunction

    function automatic void model_write(int d, logic [7:0] a, logic [31:0] data);
        int bw = (d == 1) ? 8 : 32;
        int lane = (a % 16) / 4;
        logic [31:0] m, v;
        if (a < 8'h80) begin
            if (!(d == 1 && a == 8'h00)) cfg_m[d][a / 4] = data[7:0] & 8'hEF;
        end else if (lane * bw < 32) begin
            m = (bw == 32) ? 32'hFFFF_FFFF : (32'hFF << (8 * lane));
            v = ((bw == 32) ? data : {24'h0, data[7:0]}) << (bw * lane);
            if (a / 16 == 8)  intr_m[d] = intr_m[d] & ~v;
            if (a / 16 == 10) out_m[d] = (out_m[d] & ~m) | v;
        end
        intr_m[d] = intr_m[d] | level_act(d);
    endfunction

    function automatic logic [31:0] model_read(int d, logic [7:0] a);
        int bw = (d == 1) ? 8 : 32;
        int lane = (a % 16) / 4;
        logic [31:0] src;
        if (a < 8'h80) return {24'h0, cfg_m[d][a / 4]};
        if (lane * bw >= 32) return 32'h0;
        case (int'(a / 16))
            8:       src = intr_m[d];
            9:       src = pins_m & field(d, 1);
            10:      src = out_m[d];
            default: src = 32'h0;
        endcase
        return (src >> (bw * lane)) & ((bw == 32) ? 32'hFFFF_FFFF : 32'hFF);
    endfunction

    function automatic void model_pins(logic [31:0] nv);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 32; n++) begin
                logic rise = nv[n] & ~pins_m[n];
                logic fall = ~nv[n] & pins_m[n];
                if (cfg_m[d][n][3]) begin
                    case (int'(cfg_m[d][n][7:5]))
                        2: if (rise) intr_m[d][n] = 1'b1;
                        3: if (fall) intr_m[d][n] = 1'b1;
                        4: if (rise | fall) intr_m[d][n] = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
        pins_m = nv;
        for (int d = 0; d < 2; d++) intr_m[d] = intr_m[d] | level_act(d);
    endfunction

    // Driver tasks are entered just after a rising edge and return just after one.
    task automatic step(int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic drive_write(int d, logic [7:0] a, logic [31:0] data);
        psel_a = (d == 0); psel_b = (d == 1);
        PWRITE = 1'b1; PADDR = a; PWDATA = data; PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        step(1);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(int d, logic [7:0] a, logic [31:0] data);
        model_write(d, a, data);
        drive_write(d, a, data);
    endtask

    task automatic rd(int d, logic [7:0] a);
        rd_t e;
        e.d = (d == 1); e.addr = a; e.exp = model_read(d, a);
        rd_q.push_back(e);
        psel_a = (d == 0); psel_b = (d == 1);
        PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        step(1);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic set_pins(logic [31:0] nv);
        model_pins(nv);
        gpio_in = nv;
        step(4 + SYNC);
    endtask

    task automatic chk_pins();
        for (int d = 0; d < 2; d++) begin
            pin_t p;
            p.d = (d == 1);
            p.out = out_m[d] & field(d, 0);
            p.oe = field(d, 2);
            p.intv = intr_m[d];
            p.int_or = |intr_m[d];
            pin_q.push_back(p);
        end
        step(1);
        pin_chk = 1'b1;
        step(1);
        pin_chk = 1'b0;
    endtask

    // The INTR clear is timed to land on the same edge that records the new input edge.
    task automatic clr_with_edge(logic [31:0] clr, logic [31:0] nv);
        intr_m[0] = intr_m[0] & ~clr;
        model_pins(nv);
        gpio_in = nv;
        step(SYNC);
        drive_write(0, 8'h80, clr);
        step(3 + SYNC);
    endtask

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%08h exp=%08h", name, act, exp);
        end
    endtask

    rd_t  mon_e;
    pin_t mon_p;

    always @(negedge PCLK) begin
        if (PENABLE && !PWRITE && (psel_a || psel_b)) begin
            if (rd_q.size() == 0) begin
                cmp("rd_q_empty", 32'h1, 32'h0);
            end else begin
                mon_e = rd_q.pop_front();
                cmp($sformatf("read dut%0d addr=%02h", mon_e.d, mon_e.addr),
                    mon_e.d ? {24'h0, prdata_b} : prdata_a, mon_e.exp);
                cmp("pready_pslverr", {30'h0, mon_e.d ? pready_b : pready_a, mon_e.d ? pslverr_b : pslverr_a}, 32'h2);
            end
        end
        if (pin_chk) begin
            while (pin_q.size() > 0) begin
                mon_p = pin_q.pop_front();
                cmp($sformatf("gpio_out dut%0d", mon_p.d), mon_p.d ? gout_b : gout_a, mon_p.out);
                cmp($sformatf("gpio_oe dut%0d", mon_p.d), mon_p.d ? goe_b : goe_a, mon_p.oe);
                cmp($sformatf("int dut%0d", mon_p.d), mon_p.d ? gint_b : gint_a, mon_p.intv);
                cmp($sformatf("int_or dut%0d", mon_p.d), {31'h0, mon_p.d ? int_or_b : int_or_a}, {31'h0, mon_p.int_or});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [7:0] addr_tab [14] = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h94, 8'h98, 8'h9C,
                                  8'hA0, 8'hA4, 8'hA8, 8'hAC, 8'hB0, 8'hFC};

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 2) == 0) return 8'($urandom_range(0, 31) * 4);
        return addr_tab[$urandom_range(0, 13)];
    endfunction

    initial begin
        PRESETN = 1'b0; psel_a = 0; psel_b = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PWDATA = '0; gpio_in = '0; pin_chk = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 32; n++) cfg_m[d][n] = 8'h00;
            out_m[d] = '0; intr_m[d] = '0;
        end
        cfg_m[1][0] = 8'h05;
        pins_m = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK) PRESETN = 1'b1;
        step(1);

        chk_pins();
        rd(0, 8'h00); rd(0, 8'h0C); rd(0, 8'h80); rd(0, 8'h90); rd(0, 8'hA0); rd(1, 8'h00);

        wr(0, 8'h0C, 32'h05); wr(0, 8'hA0, 32'h08);
        chk_pins(); rd(0, 8'h0C); rd(0, 8'hA0);

        wr(0, 8'h00, 32'h02); set_pins(32'hA5); rd(0, 8'h90);
        for (int n = 0; n < 32; n++) wr(0, 8'(n * 4), 32'h02);
        rd(0, 8'h90); chk_pins();

        wr(0, 8'h04, 32'h4A); set_pins(32'hA7);
        rd(0, 8'h80); chk_pins();
        wr(0, 8'h80, 32'h02); rd(0, 8'h80); step(3); rd(0, 8'h80);

        wr(0, 8'h08, 32'h0A); rd(0, 8'h80);
        wr(0, 8'h80, 32'h04); rd(0, 8'h80);
        set_pins(32'hA3); wr(0, 8'h80, 32'h04); rd(0, 8'h80); step(2); rd(0, 8'h80);

        wr(0, 8'h10, 32'h8A); set_pins(32'hB3); rd(0, 8'h80);
        wr(0, 8'h80, 32'h10); rd(0, 8'h80);
        set_pins(32'hA3); rd(0, 8'h80);
        clr_with_edge(32'h10, 32'hB3); rd(0, 8'h80); chk_pins();

        wr(1, 8'h00, 32'hFF); rd(1, 8'h00);
        for (int n = 8; n < 16; n++) wr(1, 8'(n * 4), 32'h05);
        wr(1, 8'hA4, 32'h5A); rd(1, 8'hA4); rd(1, 8'hA0); chk_pins();

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: wr(0, 8'($urandom_range(0, 31) * 4), 32'($urandom_range(0, 255)));
                1: set_pins($urandom);
                2: wr(0, 8'h80, $urandom);
                3: wr(0, 8'hA0, $urandom);
                4: rd($urandom_range(0, 1), rand_addr());
                default: wr(1, rand_addr(), 32'($urandom_range(0, 255)));
            endcase
            if (i % 10 == 9) chk_pins();
        end
        rd(0, 8'h80); rd(0, 8'h90); rd(1, 8'h84); chk_pins();

        step(3);
        if (rd_q.size() != 0 || pin_q.size() != 0) begin
            cmp("pending_checks", 32'(rd_q.size() + pin_q.size()), 32'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
